// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: turns a funct3-qualified access into one word-aligned
// request/grant/response bus transaction and returns the aligned, extended load result.
module lsu_bus_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_rd_en_i,
    input  logic                  mem_wr_en_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  load_valid_o,
    output logic                  access_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                  state_q;
    logic                    bus_req_q, bus_we_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [3:0]              bus_be_q;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, load_data_q;
    logic                    load_valid_q, access_err_q;
    logic [1:0]              off_q, size_q;
    logic                    unsigned_q;

    logic                    legal_f3, misaligned;
    logic [3:0]              be_d;
    logic [DATA_WIDTH-1:0]   wdata_d, shifted, ext_data;

    always_comb begin
        legal_f3 = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = mem_rd_en_i;
            default:                legal_f3 = 1'b0;
        endcase
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

        case (funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << addr_i[1:0];
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_i;
            end
        endcase
    end

    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ext_data = unsigned_q ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext_data = unsigned_q ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0;
            bus_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            off_q        <= 2'b0;
            size_q       <= 2'b0;
            unsigned_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_rd_en_i || mem_wr_en_i) begin
                        if (legal_f3 && !misaligned) begin
                            // A load takes priority when both enables are set.
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= ~mem_rd_en_i;
                            bus_addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            off_q       <= addr_i[1:0];
                            size_q      <= funct3_i[1:0];
                            unsigned_q  <= funct3_i[2];
                            state_q     <= StReq;
                        end else begin
                            access_err_q <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StReq: begin
                    if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= bus_we_q ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (bus_rvalid_i) begin
                        load_data_q  <= ext_data;
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    // The pipeline advances on this edge, so the instruction is not reissued.
                    load_valid_q <= 1'b0;
                    access_err_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_o = rst_ni && (((state_q == StIdle) && (mem_rd_en_i || mem_wr_en_i)) ||
                                (state_q == StReq) || (state_q == StWait));

    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign access_err_o = access_err_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_be_o     = bus_be_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator for the MEM stage of the RISC-V pipeline. It drives a request/grant/response data-memory bus, so the data memory acts purely as the responder.
- Converts a funct3-qualified byte/half/word access into a word-aligned bus transaction with byte enables and replicated store data.
- Aligns and sign/zero-extends the returned load data.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte address width; bus_addr[1:0] is always 0.
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- mem_rd_en  in  1  load present in MEM stage.
- mem_wr_en  in  1  store present in MEM stage.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_WIDTH  byte address (ALU result).
- store_data  in  32  store operand, LSB-justified.
- stall  out  1  holds the pipeline while an access is in progress.
- load_data  out  32  aligned, extended load result.
- load_valid  out  1  one-cycle pulse; load_data is updated.
- access_err  out  1  one-cycle pulse; misaligned access or illegal funct3.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  word-aligned address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_gnt  in  1  request accepted this cycle (valid only while bus_req = 1).
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Behaviour:
- Reset (rst = 0, async):
  - State goes to IDLE.
  - All outputs go to 0: stall, load_data, load_valid, access_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata.
  - bus_req drops immediately, even mid-transaction.
  - A bus_rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, with mem_rd_en or mem_wr_en = 1:
  - stall = 1 combinationally in the same cycle.
  - If both enables are high, the load wins and the store is dropped.
  - Legality:
    - Loads allow funct3 000/001/010/100/101; stores allow 000/001/010.
    - H/HU requires addr[0] = 0; W requires addr[1:0] = 0.
  - Illegal or misaligned: next state DONE with access_err registered to 1; no bus activity.
  - Legal: register bus_we, bus_addr = {addr[ADDR_WIDTH-1:2], 2'b00}, bus_be, bus_wdata, and the load offset/size; next state REQ.
- Byte enables and write data:
  - B: be = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - H: be = 4'b0011 << addr[1:0]; wdata = {2{store_data[15:0]}}.
  - W: be = 4'b1111; wdata = store_data.
  - Loads also drive the size-appropriate be.
- REQ:
  - bus_req = 1 and stall = 1.
  - Request fields stay stable until bus_gnt.
  - On bus_gnt:
    - Store: bus_req drops; next state DONE.
    - Load: bus_req drops; next state WAIT.
- WAIT:
  - stall = 1; bus_rvalid is accepted no earlier than the cycle after grant.
  - On bus_rvalid: compute sh = bus_rdata >> (8*offset).
    - B/BU: sign- or zero-extend sh[7:0].
    - H/HU: sign- or zero-extend sh[15:0].
    - W: use sh.
  - The extended value is registered into load_data; load_valid = 1; next state DONE.
- DONE:
  - stall = 0; load_valid/access_err are high for exactly this cycle.
  - Always returns to IDLE. The still-present instruction is not re-issued because the pipeline advances at this edge.
- load_data holds its value until the next successful load.
- Latency:
  - Store: gnt cycle + 1.
  - Load: rvalid cycle + 1.
  - Error: 1 cycle stall, then DONE.
- bus_gnt/bus_rvalid outside REQ/WAIT are ignored.

Test Plan:
1. SW addr = 0x0000_0010, store_data = 0xDEADBEEF, bus_gnt after 2 cycles:
   - bus_addr = 0x10, be = 1111, wdata = 0xDEADBEEF, we = 1.
   - stall is high through the gnt cycle; DONE follows with stall = 0.
2. SB addr = 0x13, store_data = 0x0000_00A5, immediate gnt:
   - be = 1000, wdata = 0xA5A5A5A5, bus_addr = 0x10.
3. LB/LBU addr = 0x12, bus_rdata = 0x0080_0000, rvalid 3 cycles after gnt:
   - LB gives load_data = 0xFFFFFF80; LBU gives 0x00000080.
   - load_valid is a 1-cycle pulse in each case.
4. LH addr = 0x11 and SW addr = 0x22:
   - access_err pulse and stall for exactly 1 cycle.
   - bus_req is never asserted; load_data is unchanged.
   - funct3 = 011 load gives the same result.
5. LW in WAIT, rst pulled low before rvalid, then rvalid arrives:
   - All outputs go to 0 immediately and state is IDLE.
   - The late rvalid produces no load_valid.
6. Back-to-back SW then LHU addr = 0x16, bus_rdata = 0xBEEF1234:
   - Two separate transactions, no duplicate issue.
   - load_data = 0x0000BEEF.
